// File: rtl/spart_echo_engine_if.sv
// spart_echo_engine_if
//   Bus between the echo engine (master) and the SPART (slave).
//   rda, tbr       : SPART status flags (slave -> master)
//   iocs, iorw     : chip select and direction (1 = read, 0 = write)
//   ioaddr         : 00 = TX/RX buffer, 10 = divisor low, 11 = divisor high
//   databus        : shared 8-bit bidirectional data bus
//   m_wdata/m_drive: master write data and output enable
//   s_rdata/s_drive: slave read data and output enable
// The tristate resolution of databus lives here so both ends of the bus
// see a single resolved net; each side only supplies data and an enable.
interface spart_echo_engine_if;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] m_wdata;
  logic       m_drive;
  logic [7:0] s_rdata;
  logic       s_drive;
  wire  [7:0] databus;

  assign databus = m_drive ? m_wdata : 8'hzz;
  assign databus = s_drive ? s_rdata : 8'hzz;

  modport master (
    input  rda, tbr, databus,
    output iocs, iorw, ioaddr, m_wdata, m_drive
  );

  modport slave (
    input  iocs, iorw, ioaddr, databus,
    output rda, tbr, s_rdata, s_drive
  );
endinterface

// File: rtl/spart_echo_engine.sv
// spart_echo_engine
//   Programs the SPART baud divisor, then echoes every received byte back
//   out through a small circular FIFO, optionally upper-casing it.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   br_cfg     : baud select 00=4800 01=9600 10=19200 11=38400
//   mode       : 0 = verbatim echo, 1 = upper-case a..z on capture
//   bus        : SPART bus (master side)
//   fifo_count : bytes currently buffered
//   overrun    : sticky flag, rda held 64 cycles against a full FIFO
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT_LOW  | write divisor low byte to addr 10
// INIT_HIGH | write divisor high byte to addr 11, latch br_cfg
// IDLE      | arbitrate: reprogram > read > write
// READ      | read RX buffer, push captured byte at end of cycle
// WRITE     | write FIFO head to TX buffer, pop at end of cycle
// GAP       | no access, lets the SPART update rda/tbr
module spart_echo_engine #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  br_cfg,
  input  logic                        mode,
  spart_echo_engine_if.master         bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [15:0] divisor_for(input int baud);
    int d;
    d = (CLK_FREQ_HZ + 8 * baud) / (16 * baud) - 1;
    return d[15:0];
  endfunction

  localparam logic [15:0] DIV_4800  = divisor_for(4800);
  localparam logic [15:0] DIV_9600  = divisor_for(9600);
  localparam logic [15:0] DIV_19200 = divisor_for(19200);
  localparam logic [15:0] DIV_38400 = divisor_for(38400);

  typedef enum logic [2:0] {
    INIT_LOW,
    INIT_HIGH,
    IDLE,
    READ,
    WRITE,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic            started_q, started_d;
  logic [1:0]      cfg_q, cfg_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [5:0]      ovr_cnt_q, ovr_cnt_d;
  logic            overrun_q, overrun_d;
  logic            iocs_q, iocs_d;
  logic            iorw_q, iorw_d;
  logic [1:0]      ioaddr_q, ioaddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            drive_q, drive_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      rx_byte;
  logic [7:0]      head;
  logic [15:0]     div_cur;

  always_comb begin
    div_cur = DIV_9600;
    case (br_cfg)
      2'b00:   div_cur = DIV_4800;
      2'b01:   div_cur = DIV_9600;
      2'b10:   div_cur = DIV_19200;
      default: div_cur = DIV_38400;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    cfg_d      = cfg_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovr_cnt_d  = ovr_cnt_q;
    overrun_d  = overrun_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = 2'b00;
    wdata_d    = 8'h00;
    drive_d    = 1'b0;

    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    head       = mem_q[rd_ptr_q];
    push       = (state_q == READ);
    pop        = (state_q == WRITE);

    rx_byte = bus.databus;
    if (mode && (rx_byte >= 8'h61) && (rx_byte <= 8'h7a)) begin
      rx_byte = rx_byte - 8'h20;
    end

    // READ and WRITE are distinct states, so push and pop never coincide.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end

    // The cycle straddling reset release is spent idle so that the first
    // full clock cycle afterwards is the INIT_LOW access.
    if (!started_q) begin
      state_d = INIT_LOW;
    end else begin
      case (state_q)
        INIT_LOW:  state_d = INIT_HIGH;
        INIT_HIGH: begin
          cfg_d   = br_cfg;
          state_d = GAP;
        end
        IDLE: begin
          if (br_cfg != cfg_q) begin
            state_d = INIT_LOW;
          end else if (bus.rda && !fifo_full) begin
            state_d = READ;
          end else if (bus.tbr && !fifo_empty) begin
            state_d = WRITE;
          end
        end
        READ:      state_d = GAP;
        WRITE:     state_d = GAP;
        GAP:       state_d = IDLE;
        default:   state_d = INIT_LOW;
      endcase
    end

    // Down-counter from 63: terminal count reached on the 64th
    // consecutive blocked cycle.
    if (bus.rda && fifo_full) begin
      if (ovr_cnt_q == 6'd0) begin
        overrun_d = 1'b1;
      end else begin
        ovr_cnt_d = ovr_cnt_q - 6'd1;
      end
    end else begin
      ovr_cnt_d = 6'd63;
    end

    // Bus outputs are registered: decode the state being entered.
    case (state_d)
      INIT_LOW: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b10;
        wdata_d  = div_cur[7:0];
        drive_d  = 1'b1;
      end
      INIT_HIGH: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b11;
        wdata_d  = div_cur[15:8];
        drive_d  = 1'b1;
      end
      READ: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
      end
      WRITE: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b00;
        wdata_d  = head;
        drive_d  = 1'b1;
      end
      default: begin
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_LOW;
      started_q <= 1'b0;
      cfg_q     <= 2'b00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_cnt_q <= 6'd63;
      overrun_q <= 1'b0;
      iocs_q    <= 1'b0;
      iorw_q    <= 1'b1;
      ioaddr_q  <= 2'b00;
      wdata_q   <= 8'h00;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      cfg_q     <= cfg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_cnt_q <= ovr_cnt_d;
      overrun_q <= overrun_d;
      iocs_q    <= iocs_d;
      iorw_q    <= iorw_d;
      ioaddr_q  <= ioaddr_d;
      wdata_q   <= wdata_d;
      drive_q   <= drive_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  assign bus.iocs    = iocs_q;
  assign bus.iorw    = iorw_q;
  assign bus.ioaddr  = ioaddr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_drive = drive_q;
  assign fifo_count  = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spart_echo_engine.sv
module tb_spart_echo_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       mode = 1'b0;
  logic [3:0] fifo_count;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rda_rise_cyc = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [1:0] log_addr[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];
  int         rd_cyc_q[$];
  int         wr_cyc_q[$];

  spart_echo_engine_if bus();

  spart_echo_engine #(.CLK_FREQ_HZ(50000000), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg     (br_cfg),
    .mode       (mode),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
    return b;
  endfunction

  // SPART model and bus logger; the expected echo stream is built from
  // each byte the SPART hands over and the mode in force at that moment.
  always @(negedge clk) begin
    logic [7:0] d;
    cyc++;
    bus.s_drive = 1'b0;
    if (rst_n && bus.iocs) begin
      d = 8'h00;
      if (bus.iorw) begin
        if (rx_q.size() != 0) d = rx_q.pop_front();
        bus.s_rdata = d;
        bus.s_drive = 1'b1;
        exp_q.push_back(mode ? upper(d) : d);
        rd_cyc_q.push_back(cyc);
      end else begin
        d = bus.databus;
        if (bus.ioaddr == 2'b00) begin
          tx_q.push_back(d);
          wr_cyc_q.push_back(cyc);
        end
      end
      log_addr.push_back(bus.ioaddr);
      log_data.push_back(d);
      log_cyc.push_back(cyc);
    end
    if (rx_q.size() != 0 && !bus.rda) rda_rise_cyc = cyc;
    bus.rda = (rx_q.size() != 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    exp_q.delete(); tx_q.delete(); log_addr.delete(); log_data.delete();
    log_cyc.delete(); rd_cyc_q.delete(); wr_cyc_q.delete();
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_rx_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() == 0) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset();
    int rel;
    rst_n = 1'b0; bus.tbr = 1'b0; br_cfg = 2'b01; mode = 1'b0;
    tick(3);
    checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL reset_iocs: got %b expected 0", bus.iocs); end
    checks++; if (bus.iorw !== 1'b1) begin errors++; $display("FAIL reset_iorw: got %b expected 1", bus.iorw); end
    checks++; if (bus.ioaddr !== 2'b00) begin errors++; $display("FAIL reset_ioaddr: got %b expected 00", bus.ioaddr); end
    checks++; if (bus.m_drive !== 1'b0) begin errors++; $display("FAIL reset_databus_drive: got %b expected 0", bus.m_drive); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    clear_logs();
    rel = cyc;
    rst_n = 1'b1;
    tick(10);
    checks++; if (log_addr.size() != 2) begin errors++; $display("FAIL init_access_count: got %0d expected 2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      checks++; if (log_addr[0] !== 2'b10 || log_data[0] !== 8'h45) begin errors++; $display("FAIL init_low: got addr %b data %h expected addr 10 data 45", log_addr[0], log_data[0]); end
      checks++; if (log_addr[1] !== 2'b11 || log_data[1] !== 8'h01) begin errors++; $display("FAIL init_high: got addr %b data %h expected addr 11 data 01", log_addr[1], log_data[1]); end
      checks++; if (log_cyc[0] != rel + 2) begin errors++; $display("FAIL init_first_cycle: got %0d expected %0d", log_cyc[0], rel + 2); end
      checks++; if (log_cyc[1] != log_cyc[0] + 1) begin errors++; $display("FAIL init_consecutive: got %0d expected %0d", log_cyc[1], log_cyc[0] + 1); end
    end
  endtask

  task automatic test_upper_latency();
    bit ok;
    clear_logs();
    mode = 1'b1; bus.tbr = 1'b1;
    rx_q.push_back(8'h61);
    wait_tx(1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL latency_timeout: got 0 writes expected 1"); end
    if (ok && rd_cyc_q.size() >= 1) begin
      checks++; if (tx_q[0] !== 8'h41) begin errors++; $display("FAIL upper_data: got %h expected 41", tx_q[0]); end
      checks++; if (rd_cyc_q[0] - rda_rise_cyc != 1) begin errors++; $display("FAIL read_latency: got %0d expected 1", rd_cyc_q[0] - rda_rise_cyc); end
      checks++; if (wr_cyc_q[0] - rda_rise_cyc != 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", wr_cyc_q[0] - rda_rise_cyc); end
    end
    tick(4);
  endtask

  task automatic test_mode_at_push();
    bit ok;
    logic [7:0] want [3];
    want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h63;
    clear_logs();
    bus.tbr = 1'b0; mode = 1'b1;
    rx_q.push_back(8'h61); rx_q.push_back(8'h62);
    wait_rx_empty(40, ok);
    mode = 1'b0;
    rx_q.push_back(8'h63);
    wait_rx_empty(40, ok);
    tick(3);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL mode_count: got %0d expected 3", fifo_count); end
    mode = 1'b1;
    bus.tbr = 1'b1;
    wait_tx(3, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mode_timeout: got %0d writes expected 3", tx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < tx_q.size()) begin
        checks++; if (tx_q[i] !== want[i]) begin errors++; $display("FAIL mode_byte%0d: got %h expected %h", i, tx_q[i], want[i]); end
      end
    end
    mode = 1'b0;
    tick(4);
  endtask

  task automatic test_random_echo();
    bit ok;
    int tot = 0;
    clear_logs();
    for (int r = 0; r < 12; r++) begin
      int k;
      mode = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1) rx_q.push_back(8'($urandom_range(8'h5b, 8'h80)));
        else rx_q.push_back(8'($urandom));
        tot++;
      end
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        bus.tbr = 1'($urandom_range(0, 1));
        tick(1);
        if (rx_q.size() == 0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL random_rx_stall: got %0d pending expected 0", rx_q.size()); end
    end
    bus.tbr = 1'b1;
    wait_tx(tot, 400, ok);
    checks++; if (tx_q.size() != tot) begin errors++; $display("FAIL random_count: got %0d expected %0d", tx_q.size(), tot); end
    for (int i = 0; i < tot; i++) begin
      if (i < tx_q.size() && i < exp_q.size()) begin
        checks++; if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte%0d: got %h expected %h", i, tx_q[i], exp_q[i]); end
      end
    end
    tick(3);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL random_empty: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_fill_overrun();
    bit ok;
    clear_logs();
    bus.tbr = 1'b0; mode = 1'b0;
    for (int i = 0; i < 9; i++) rx_q.push_back(8'($urandom));
    tick(40);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", fifo_count); end
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL fill_no_ninth_read: got %0d pending expected 1", rx_q.size()); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", overrun); end
    tick(64);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    bus.tbr = 1'b1;
    wait_tx(9, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_timeout: got %0d writes expected 9", tx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < tx_q.size() && i < exp_q.size()) begin
        checks++; if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_byte%0d: got %h expected %h", i, tx_q[i], exp_q[i]); end
      end
    end
    if (rd_cyc_q.size() == 9 && wr_cyc_q.size() >= 1) begin
      checks++; if (rd_cyc_q[8] <= wr_cyc_q[0]) begin errors++; $display("FAIL ninth_read_order: got cycle %0d expected after %0d", rd_cyc_q[8], wr_cyc_q[0]); end
    end
    tick(3);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_empty: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_baud_change();
    bit ok;
    int mark;
    clear_logs();
    bus.tbr = 1'b0; mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) rx_q.push_back(8'($urandom));
    wait_rx_empty(40, ok);
    tick(3);
    mark = log_addr.size();
    br_cfg = 2'b11;
    tick(12);
    checks++; if (log_addr.size() != mark + 2) begin errors++; $display("FAIL baud_access_count: got %0d expected %0d", log_addr.size(), mark + 2); end
    if (log_addr.size() >= mark + 2) begin
      checks++; if (log_addr[mark] !== 2'b10 || log_data[mark] !== 8'h50) begin errors++; $display("FAIL baud_low: got addr %b data %h expected addr 10 data 50", log_addr[mark], log_data[mark]); end
      checks++; if (log_addr[mark+1] !== 2'b11 || log_data[mark+1] !== 8'h00) begin errors++; $display("FAIL baud_high: got addr %b data %h expected addr 11 data 00", log_addr[mark+1], log_data[mark+1]); end
    end
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL baud_count: got %0d expected 3", fifo_count); end
    bus.tbr = 1'b1;
    wait_tx(3, 60, ok);
    checks++; if (tx_q.size() != 3) begin errors++; $display("FAIL baud_resume: got %0d writes expected 3", tx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < tx_q.size() && i < exp_q.size()) begin
        checks++; if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL baud_byte%0d: got %h expected %h", i, tx_q[i], exp_q[i]); end
      end
    end
    tick(3);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit found;
    clear_logs();
    bus.tbr = 1'b0; mode = 1'b0;
    rx_q.push_back(8'($urandom)); rx_q.push_back(8'($urandom));
    wait_rx_empty(40, ok);
    tick(3);
    bus.tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midwrite_found: got 0 expected 1"); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL midwrite_iocs: got %b expected 0", bus.iocs); end
    checks++; if (bus.m_drive !== 1'b0) begin errors++; $display("FAIL midwrite_hiz: got %b expected 0", bus.m_drive); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL midwrite_count: got %0d expected 0", fifo_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midwrite_overrun: got %b expected 0", overrun); end
    tick(2);
    br_cfg = 2'b01;
    clear_logs();
    rst_n = 1'b1;
    tick(10);
    checks++; if (log_addr.size() != 2) begin errors++; $display("FAIL reinit_count: got %0d expected 2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      checks++; if (log_addr[0] !== 2'b10 || log_data[0] !== 8'h45) begin errors++; $display("FAIL reinit_low: got addr %b data %h expected addr 10 data 45", log_addr[0], log_data[0]); end
      checks++; if (log_addr[1] !== 2'b11 || log_data[1] !== 8'h01) begin errors++; $display("FAIL reinit_high: got addr %b data %h expected addr 11 data 01", log_addr[1], log_data[1]); end
    end
  endtask

  initial begin
    bus.tbr = 1'b0;
    bus.rda = 1'b0;
    bus.s_drive = 1'b0;
    bus.s_rdata = 8'h00;
    test_reset();
    test_upper_latency();
    test_mode_at_push();
    test_random_echo();
    test_fill_overrun();
    test_baud_change();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
